// File: rtl/posloc_pkg.sv
// Shared definitions for the position locator AXI4-Lite slave: register map,
// response codes and FSM state types.
package posloc_pkg;

   localparam int unsigned NUM_REGS   = 4;
   localparam int unsigned REG_CTRL   = 0;
   localparam int unsigned REG_POS_X  = 1;
   localparam int unsigned REG_POS_Y  = 2;
   localparam int unsigned REG_STATUS = 3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_COMMIT,
      WR_RESP
   } wr_state_e;

   typedef enum logic {
      RD_IDLE,
      RD_DATA
   } rd_state_e;

   // Word slots 0..3 hold registers; slots 4..7 are decoded but unmapped.
   function automatic logic idx_mapped(input logic [2:0] idx);
      return 32'(idx) <= REG_STATUS;
   endfunction

endpackage

// File: rtl/posloc_wstrb_merge.sv
// Byte-lane merge: each WSTRB bit selects the new byte from WDATA, otherwise
// the old register byte is kept.
module posloc_wstrb_merge #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]   old_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   output logic [DATA_WIDTH-1:0]   merged_o
);

   always_comb begin
      // NOTE: assigning a default before any conditional write keeps this
      // block purely combinational; a missing default path infers a latch.
      merged_o = old_i;
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
         if (wstrb_i[b]) merged_o[b*8 +: 8] = wdata_i[b*8 +: 8];
      end
   end

endmodule

// File: rtl/posloc_axil_slave.sv
// AXI4-Lite register file for the position locator (four 32-bit registers).
// Define POSLOC_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module posloc_axil_slave
   import posloc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
   input  logic [2:0]                   S_AXI_AWPROT,
   input  logic                         S_AXI_AWVALID,
   output logic                         S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
   input  logic                         S_AXI_WVALID,
   output logic                         S_AXI_WREADY,
   output logic [1:0]                   S_AXI_BRESP,
   output logic                         S_AXI_BVALID,
   input  logic                         S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
   input  logic [2:0]                   S_AXI_ARPROT,
   input  logic                         S_AXI_ARVALID,
   output logic                         S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
   output logic [1:0]                   S_AXI_RRESP,
   output logic                         S_AXI_RVALID,
   input  logic                         S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]          reg_wr
);

`ifdef POSLOC_SLVERR_EN
   localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
   localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

   wr_state_e wr_state_q, wr_state_d;
   rd_state_e rd_state_q, rd_state_d;

   logic                    aw_full_q, aw_full_d;
   logic [2:0]              aw_idx_q, aw_idx_d;
   logic                    w_full_q, w_full_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]     reg_wr_q, reg_wr_d;
   logic [DATA_WIDTH-1:0]   merged;
   logic [2:0]              ar_idx;
   logic                    unused_bits;

   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   assign S_AXI_AWREADY = !aw_full_q && (wr_state_q == WR_IDLE);
   assign S_AXI_WREADY  = !w_full_q && (wr_state_q == WR_IDLE);
   assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = (rd_state_q == RD_IDLE);
   assign S_AXI_RVALID  = (rd_state_q == RD_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign reg_wr        = reg_wr_q;
   assign ar_idx        = S_AXI_ARADDR[4:2];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

   posloc_wstrb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
      .old_i    (regs_q[aw_idx_q[1:0]]),
      .wdata_i  (wdata_q),
      .wstrb_i  (wstrb_q),
      .merged_o (merged)
   );

   always_comb begin
      wr_state_d = wr_state_q;
      aw_full_d  = aw_full_q;
      aw_idx_d   = aw_idx_q;
      w_full_d   = w_full_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      regs_d     = regs_q;
      reg_wr_d   = '0;
      case (wr_state_q)
         WR_IDLE: begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
               aw_full_d = 1'b1;
               aw_idx_d  = S_AXI_AWADDR[4:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
               w_full_d = 1'b1;
               wdata_d  = S_AXI_WDATA;
               wstrb_d  = S_AXI_WSTRB;
            end
            if (aw_full_d && w_full_d) wr_state_d = WR_COMMIT;
         end
         WR_COMMIT: begin
            aw_full_d  = 1'b0;
            w_full_d   = 1'b0;
            wr_state_d = WR_RESP;
            if (idx_mapped(aw_idx_q)) begin
               regs_d[aw_idx_q[1:0]]   = merged;
               reg_wr_d[aw_idx_q[1:0]] = 1'b1;
               bresp_d                 = RESP_OKAY;
            end else begin
               bresp_d = UNMAPPED_RESP;
            end
         end
         WR_RESP: begin
            if (S_AXI_BREADY) wr_state_d = WR_IDLE;
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Reads sample regs_q, so a read alongside a COMMIT sees the pre-write value.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (S_AXI_ARVALID) begin
               rd_state_d = RD_DATA;
               if (idx_mapped(ar_idx)) begin
                  rdata_d = regs_q[ar_idx[1:0]];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = '0;
                  rresp_d = UNMAPPED_RESP;
               end
            end
         end
         RD_DATA: begin
            if (S_AXI_RREADY) rd_state_d = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its _d value from before the edge.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_state_q <= WR_IDLE;
         rd_state_q <= RD_IDLE;
         aw_full_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_full_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         reg_wr_q   <= '0;
         // NOTE: this small register file is software-visible state with a
         // defined reset value, so unlike a RAM it is reset explicitly.
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         aw_full_q  <= aw_full_d;
         aw_idx_q   <= aw_idx_d;
         w_full_q   <= w_full_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         reg_wr_q   <= reg_wr_d;
         regs_q     <= regs_d;
      end
   end

endmodule

// File: tb/tb_posloc_axil_slave.sv
// Directed scoreboard bench for posloc_axil_slave; build with +define+POSLOC_SLVERR_EN
// to exercise the SLVERR configuration.
module tb_posloc_axil_slave;

`ifdef POSLOC_SLVERR_EN
   localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
   localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif
   localparam logic [1:0] OKAY = 2'b00;

   logic          clk = 1'b0;
   logic          ARESET;
   logic [4:0]    S_AXI_AWADDR;
   logic [2:0]    S_AXI_AWPROT;
   logic          S_AXI_AWVALID;
   logic          S_AXI_AWREADY;
   logic [31:0]   S_AXI_WDATA;
   logic [3:0]    S_AXI_WSTRB;
   logic          S_AXI_WVALID;
   logic          S_AXI_WREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_BVALID;
   logic          S_AXI_BREADY;
   logic [4:0]    S_AXI_ARADDR;
   logic [2:0]    S_AXI_ARPROT;
   logic          S_AXI_ARVALID;
   logic          S_AXI_ARREADY;
   logic [31:0]   S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;
   logic          S_AXI_RVALID;
   logic          S_AXI_RREADY;
   logic [127:0]  reg_q;
   logic [3:0]    reg_wr;

   int tests = 0;
   int fails = 0;
   logic [1:0]  bq [$];
   logic [33:0] rq [$];
   logic [31:0] exp_regs [4];

   always #5 clk = ~clk;

   posloc_axil_slave dut (
      .ACLK          (clk),
      .ARESET        (ARESET),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .reg_q         (reg_q),
      .reg_wr        (reg_wr)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] exp_flat();
      return {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_b(input string tag);
      if (bq.size() == 0) check({tag, "_bq_empty"}, 128'(1'b1), 128'(1'b0));
      else check({tag, "_bresp"}, 128'(S_AXI_BRESP), 128'(bq.pop_front()));
   endtask

   task automatic pop_r(input string tag);
      logic [33:0] e;
      if (rq.size() == 0) check({tag, "_rq_empty"}, 128'(1'b1), 128'(1'b0));
      else begin
         e = rq.pop_front();
         check({tag, "_rdata"}, 128'(S_AXI_RDATA), 128'(e[31:0]));
         check({tag, "_rresp"}, 128'(S_AXI_RRESP), 128'(e[33:32]));
      end
   endtask

   // Presents AW after aw_dly cycles and W after w_dly cycles, then checks
   // the two-cycle commit latency, the reg_wr pulse and the response.
   task automatic axi_write(input string tag, input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input logic [31:0] exp_val, input logic [3:0] exp_wr,
                            input logic [1:0] exp_resp);
      int cyc = 0;
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      bq.push_back(exp_resp);
      if (exp_wr != 4'b0) exp_regs[addr[3:2]] = exp_val;
      S_AXI_AWADDR = addr;
      S_AXI_WDATA  = data;
      S_AXI_WSTRB  = strb;
      while (!(aw_done && w_done) && cyc < 20) begin
         S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
         S_AXI_WVALID  = !w_done && cyc >= w_dly;
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         check({tag, "_no_early_b"}, 128'(S_AXI_BVALID), 128'(1'b0));
         tick();
         aw_done |= aw_hs;
         w_done  |= w_hs;
         cyc++;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      check({tag, "_accepted"}, 128'(aw_done && w_done), 128'(1'b1));
      check({tag, "_commit_bvalid"}, 128'(S_AXI_BVALID), 128'(1'b0));
      tick();
      check({tag, "_bvalid"}, 128'(S_AXI_BVALID), 128'(1'b1));
      check({tag, "_reg_wr"}, 128'(reg_wr), 128'(exp_wr));
      check({tag, "_reg_q"}, reg_q, exp_flat());
      pop_b(tag);
      tick();
      check({tag, "_single_b"}, 128'(S_AXI_BVALID), 128'(1'b0));
      check({tag, "_pulse_end"}, 128'(reg_wr), 128'(4'b0));
   endtask

   task automatic axi_read(input string tag, input logic [4:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      int cyc = 0;
      bit hs = 0;
      rq.push_back({exp_resp, exp_data});
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      while (!hs && cyc < 20) begin
         hs = S_AXI_ARREADY;
         tick();
         cyc++;
      end
      S_AXI_ARVALID = 1'b0;
      check({tag, "_ar_accepted"}, 128'(hs), 128'(1'b1));
      check({tag, "_rvalid"}, 128'(S_AXI_RVALID), 128'(1'b1));
      pop_r(tag);
      tick();
      check({tag, "_single_r"}, 128'(S_AXI_RVALID), 128'(1'b0));
   endtask

   initial begin
      ARESET        = 1'b1;
      S_AXI_AWADDR  = '0;
      S_AXI_AWPROT  = '0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA   = '0;
      S_AXI_WSTRB   = '0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b1;
      S_AXI_ARADDR  = '0;
      S_AXI_ARPROT  = '0;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      for (int i = 0; i < 4; i++) exp_regs[i] = '0;

      repeat (25) tick();
      check("rst_reg_q", reg_q, 128'(0));
      check("rst_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
      check("rst_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
      check("rst_resp_data", 128'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 128'(0));
      check("rst_reg_wr", 128'(reg_wr), 128'(0));
      ARESET = 1'b0;
      tick();

      axi_write("w_ctrl", 5'h00, 32'h0101FFFF, 4'hF, 0, 0, 32'h0101FFFF, 4'b0001, OKAY);
      axi_read("r_ctrl", 5'h00, 32'h0101FFFF, OKAY);
      axi_write("w_posx", 5'h04, 32'hABCD0001, 4'hF, 0, 0, 32'hABCD0001, 4'b0010, OKAY);
      axi_read("r_posx", 5'h04, 32'hABCD0001, OKAY);
      axi_write("w_posy", 5'h08, 32'hDEAD0011, 4'hF, 0, 0, 32'hDEAD0011, 4'b0100, OKAY);
      axi_read("r_posy", 5'h08, 32'hDEAD0011, OKAY);
      axi_write("w_stat", 5'h0C, 32'hBEEF0011, 4'hF, 0, 0, 32'hBEEF0011, 4'b1000, OKAY);
      axi_read("r_stat", 5'h0C, 32'hBEEF0011, OKAY);

      axi_write("w_first", 5'h04, 32'h12345678, 4'hF, 3, 0, 32'h12345678, 4'b0010, OKAY);
      axi_write("w_same", 5'h04, 32'h12345678, 4'hF, 0, 0, 32'h12345678, 4'b0010, OKAY);
      axi_read("r_order", 5'h06, 32'h12345678, OKAY);

      // Lanes 0 and 2 take the new bytes DD and BB; lanes 1 and 3 keep 00 and DE.
      axi_write("w_strb", 5'h08, 32'hAABBCCDD, 4'b0101, 0, 0, 32'hDEBB00DD, 4'b0100, OKAY);
      axi_read("r_strb", 5'h08, 32'hDEBB00DD, OKAY);
      axi_write("w_strb0", 5'h0C, 32'h00000000, 4'b0000, 0, 0, 32'hBEEF0011, 4'b1000, OKAY);
      axi_read("r_strb0", 5'h0C, 32'hBEEF0011, OKAY);

      axi_write("w_unmap", 5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0, 4'b0000, UNMAPPED_RESP);
      axi_read("r_unmap", 5'h1C, 32'h0, UNMAPPED_RESP);

      // Backpressure: write to reg0 and read reg1 together with both READYs low.
      S_AXI_BREADY  = 1'b0;
      S_AXI_RREADY  = 1'b0;
      S_AXI_AWADDR  = 5'h00;
      S_AXI_WDATA   = 32'h55AA55AA;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_ARADDR  = 5'h04;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      S_AXI_ARVALID = 1'b1;
      bq.push_back(OKAY);
      rq.push_back({OKAY, 32'h12345678});
      exp_regs[0] = 32'h55AA55AA;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARVALID = 1'b0;
      check("bp_rvalid_n1", 128'(S_AXI_RVALID), 128'(1'b1));
      pop_r("bp");
      tick();
      check("bp_bvalid_n2", 128'(S_AXI_BVALID), 128'(1'b1));
      check("bp_reg_wr", 128'(reg_wr), 128'(4'b0001));
      check("bp_reg_q", reg_q, exp_flat());
      pop_b("bp");
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_hold_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b11));
         check("bp_hold_rdata", 128'(S_AXI_RDATA), 128'(32'h12345678));
         check("bp_hold_resp", 128'({S_AXI_BRESP, S_AXI_RRESP}), 128'(4'b0000));
      end

      ARESET = 1'b1;
      #1;
      check("mid_rst_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
      check("mid_rst_reg_q", reg_q, 128'(0));
      check("mid_rst_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
      for (int i = 0; i < 4; i++) exp_regs[i] = '0;
      S_AXI_BREADY = 1'b1;
      S_AXI_RREADY = 1'b1;
      repeat (2) tick();
      ARESET = 1'b0;
      repeat (3) begin
         tick();
         check("post_rst_no_resp", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
      end
      axi_read("r_post_rst", 5'h00, 32'h0, OKAY);
      axi_write("w_post_rst", 5'h08, 32'hCAFEF00D, 4'hF, 0, 2, 32'hCAFEF00D, 4'b0100, OKAY);
      check("sb_drained", 128'(bq.size() + rq.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
